// File: rtl/fht_stage_ctrl_if.sv
// Signal bundle between the FHT stage sequencer and the datapath / host that uses it.
// iSTART is a level request, taken only while the sequencer is idle. There is no ready
// signal: oBUSY rising is the acceptance. oRD_EN/oWR_EN are one-cycle qualifiers for
// the addresses driven alongside them in the same cycle.
interface fht_stage_ctrl_if #(
  parameter int A_BIT = 4,
  parameter int S_BIT = 2
);
  logic             iSTART;
  logic             oBUSY;
  logic             oDONE;
  logic [S_BIT-1:0] oSTAGE;
  logic             oRD_EN;
  logic [A_BIT-1:0] oRD_ADR0;
  logic [A_BIT-1:0] oRD_ADR1;
  logic [A_BIT-1:0] oRD_ADR2;
  logic [A_BIT-2:0] oW_ADR;
  logic             oRD_BANK;
  logic             oWR_EN;
  logic [A_BIT-1:0] oWR_ADR0;
  logic [A_BIT-1:0] oWR_ADR1;
  logic             oWR_BANK;
  logic             oRES_BANK;
  logic [1:0]       dbg_state;

  modport master (
    input  iSTART,
    output oBUSY, oDONE, oSTAGE, oRD_EN, oRD_ADR0, oRD_ADR1, oRD_ADR2, oW_ADR,
           oRD_BANK, oWR_EN, oWR_ADR0, oWR_ADR1, oWR_BANK, oRES_BANK, dbg_state
  );

  modport slave (
    output iSTART,
    input  oBUSY, oDONE, oSTAGE, oRD_EN, oRD_ADR0, oRD_ADR1, oRD_ADR2, oW_ADR,
           oRD_BANK, oWR_EN, oWR_ADR0, oWR_ADR1, oWR_BANK, oRES_BANK, dbg_state
  );
endinterface

// File: rtl/fht_stage_ctrl.sv
// Stage sequencer for a radix-2 FHT over ping-pong RAM banks: issues one butterfly per
// cycle, then drains the read+butterfly pipeline before starting the next stage.
module fht_stage_ctrl #(
  parameter int A_BIT   = 4,
  parameter int S_BIT   = 2,
  parameter int RD_LAT  = 1,
  parameter int BUT_LAT = 2
) (
  input  logic           iCLK,
  input  logic           iRESET,
  fht_stage_ctrl_if.master bus
);

  localparam int D  = RD_LAT + BUT_LAT;
  localparam int DW = (D > 1) ? $clog2(D) : 1;

  localparam logic [A_BIT-2:0] J_LAST = '1;
  localparam logic [A_BIT-2:0] J_ONE  = 1;
  localparam logic [S_BIT-1:0] S_LAST = S_BIT'(A_BIT - 1);
  localparam logic [S_BIT-1:0] S_ONE  = 1;
  localparam logic [DW-1:0]    D_LAST = DW'(D - 1);
  localparam logic [DW-1:0]    D_ONE  = 1;
  localparam logic [A_BIT-1:0] A_ONE  = 1;
  localparam logic             RES_BANK = 1'(A_BIT % 2);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [S_BIT-1:0] s_q, s_d;
  logic [A_BIT-2:0] j_q, j_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic             bank_q, bank_d;
  logic             busy_d;

  // Registered outputs
  logic             busy_q, done_q, rd_en_q, rd_bank_q, wr_bank_q, res_bank_q;
  logic [S_BIT-1:0] stage_q;
  logic [A_BIT-1:0] rd_adr0_q, rd_adr1_q, rd_adr2_q;
  logic [A_BIT-2:0] w_adr_q;

  // Write-back delay line
  logic [D-1:0]     en_sr;
  logic [A_BIT-1:0] a0_sr [D];
  logic [A_BIT-1:0] a1_sr [D];

  // Butterfly addresses for the upcoming cycle
  logic [A_BIT-1:0] jj, half, k, b;
  logic [A_BIT-1:0] a0_d, a1_d, a2_d;
  logic [A_BIT-2:0] w_d;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    dcnt_d  = dcnt_q;
    bank_d  = bank_q;
    case (state_q)
      IDLE: begin
        if (bus.iSTART) begin
          state_d = RUN;
          s_d     = '0;
          j_d     = '0;
          bank_d  = 1'b0;
        end
      end
      RUN: begin
        if (j_q == J_LAST) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end else begin
          j_d = j_q + J_ONE;
        end
      end
      DRAIN: begin
        if (dcnt_q == D_LAST) begin
          if (s_q < S_LAST) begin
            state_d = RUN;
            s_d     = s_q + S_ONE;
            j_d     = '0;
            bank_d  = ~bank_q;
          end else begin
            state_d = DONE;
          end
        end else begin
          dcnt_d = dcnt_q + D_ONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d == RUN) || (state_d == DRAIN);

  // Group base b is the butterfly group index times the group span 2^(s+1); the span
  // wraps to zero in the last stage, which still yields b + L - k correctly mod N.
  always_comb begin
    jj   = A_BIT'(j_d);
    half = A_ONE << s_d;
    k    = jj & (half - A_ONE);
    b    = (jj >> s_d) << (int'(s_d) + 1);
    a0_d = b + k;
    a1_d = b + half + k;
    a2_d = (k == '0) ? (b + half) : (b + (half << 1) - k);
    w_d  = (A_BIT-1)'(k << (A_BIT - 1 - int'(s_d)));
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q <= IDLE;
      s_q     <= '0;
      j_q     <= '0;
      dcnt_q  <= '0;
      bank_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      j_q     <= j_d;
      dcnt_q  <= dcnt_d;
      bank_q  <= bank_d;
    end
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      stage_q    <= '0;
      rd_en_q    <= 1'b0;
      rd_adr0_q  <= '0;
      rd_adr1_q  <= '0;
      rd_adr2_q  <= '0;
      w_adr_q    <= '0;
      rd_bank_q  <= 1'b0;
      wr_bank_q  <= 1'b0;
      res_bank_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= (state_d == DONE);
      stage_q    <= busy_d ? s_d : '0;
      rd_en_q    <= (state_d == RUN);
      rd_adr0_q  <= (state_d == RUN) ? a0_d : '0;
      rd_adr1_q  <= (state_d == RUN) ? a1_d : '0;
      rd_adr2_q  <= (state_d == RUN) ? a2_d : '0;
      w_adr_q    <= (state_d == RUN) ? w_d  : '0;
      rd_bank_q  <= busy_d ? bank_d : 1'b0;
      wr_bank_q  <= busy_d ? ~bank_d : 1'b0;
      res_bank_q <= (state_d == DONE) ? RES_BANK : 1'b0;
    end
  end

  // No flush on stage change: DRAIN lasts exactly D cycles, so the line is empty by then.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      en_sr <= '0;
      for (int i = 0; i < D; i++) begin
        a0_sr[i] <= '0;
        a1_sr[i] <= '0;
      end
    end else begin
      en_sr[0] <= rd_en_q;
      a0_sr[0] <= rd_adr0_q;
      a1_sr[0] <= rd_adr1_q;
      for (int i = 1; i < D; i++) begin
        en_sr[i] <= en_sr[i-1];
        a0_sr[i] <= a0_sr[i-1];
        a1_sr[i] <= a1_sr[i-1];
      end
    end
  end

  assign bus.oBUSY     = busy_q;
  assign bus.oDONE     = done_q;
  assign bus.oSTAGE    = stage_q;
  assign bus.oRD_EN    = rd_en_q;
  assign bus.oRD_ADR0  = rd_adr0_q;
  assign bus.oRD_ADR1  = rd_adr1_q;
  assign bus.oRD_ADR2  = rd_adr2_q;
  assign bus.oW_ADR    = w_adr_q;
  assign bus.oRD_BANK  = rd_bank_q;
  assign bus.oWR_EN    = en_sr[D-1];
  assign bus.oWR_ADR0  = a0_sr[D-1];
  assign bus.oWR_ADR1  = a1_sr[D-1];
  assign bus.oWR_BANK  = wr_bank_q;
  assign bus.oRES_BANK = res_bank_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_fht_stage_ctrl.sv
// Bench for fht_stage_ctrl: random start/idle/reset timing checked cycle by cycle against
// an arithmetic model of the transform schedule.
module tb_fht_stage_ctrl;

  localparam int A_BIT   = 4;
  localparam int S_BIT   = 2;
  localparam int RD_LAT  = 1;
  localparam int BUT_LAT = 2;
  localparam int N       = 1 << A_BIT;
  localparam int NH      = N / 2;
  localparam int D       = RD_LAT + BUT_LAT;
  localparam int P       = NH + D;
  localparam int TOTAL   = A_BIT * P;

  logic iCLK = 1'b0;
  logic iRESET;

  fht_stage_ctrl_if #(.A_BIT(A_BIT), .S_BIT(S_BIT)) bus ();

  fht_stage_ctrl #(
    .A_BIT(A_BIT), .S_BIT(S_BIT), .RD_LAT(RD_LAT), .BUT_LAT(BUT_LAT)
  ) dut (
    .iCLK(iCLK),
    .iRESET(iRESET),
    .bus(bus.master)
  );

  // ---------------- clock / reset ----------------
  always #5 iCLK = ~iCLK;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int cur_c = 0;
  int wr_cnt;

  typedef struct {
    int busy, done, stage, rd_en, a0, a1, a2, w, rd_bank, wr_bank, res_bank;
  } exp_t;

  // Reference schedule: cycle c (1-based from first RUN cycle) of a transform.
  function automatic exp_t model(int c);
    exp_t e;
    int st, off, half, k, b;
    e = '{default: 0};
    if (c >= 1 && c <= TOTAL) begin
      st = (c - 1) / P;
      off = (c - 1) % P;
      e.busy = 1;
      e.stage = st;
      e.rd_bank = st % 2;
      e.wr_bank = 1 - (st % 2);
      if (off < NH) begin
        half = 1 << st;
        k = off % half;
        b = (off / half) * (2 * half);
        e.rd_en = 1;
        e.a0 = b + k;
        e.a1 = b + half + k;
        e.a2 = (k == 0) ? (b + half) : (b + 2 * half - k);
        e.w = k * (NH / half);
      end
    end
    if (c == TOTAL + 1) begin
      e.done = 1;
      e.res_bank = A_BIT % 2;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    total++;
    assert (obs === 32'(exp))
      else begin
        bad++;
        $error("FAIL %s c=%0d obs=%0h exp=%0h", tag, cur_c, obs, exp);
      end
  endtask

  function automatic logic [31:0] all_outs();
    return {bus.oBUSY, bus.oDONE, bus.oSTAGE, bus.oRD_EN, bus.oRD_ADR0, bus.oRD_ADR1,
            bus.oRD_ADR2, bus.oW_ADR, bus.oRD_BANK, bus.oWR_EN, bus.oWR_ADR0,
            bus.oWR_ADR1, bus.oWR_BANK, bus.oRES_BANK};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check(tag, all_outs(), 0);
  endtask

  task automatic check_cycle(input int c);
    exp_t e, w;
    e = model(c);
    w = model(c - D);
    cur_c = c;
    check("busy",     32'(bus.oBUSY),     e.busy);
    check("done",     32'(bus.oDONE),     e.done);
    check("stage",    32'(bus.oSTAGE),    e.stage);
    check("rd_en",    32'(bus.oRD_EN),    e.rd_en);
    check("rd_adr0",  32'(bus.oRD_ADR0),  e.a0);
    check("rd_adr1",  32'(bus.oRD_ADR1),  e.a1);
    check("rd_adr2",  32'(bus.oRD_ADR2),  e.a2);
    check("w_adr",    32'(bus.oW_ADR),    e.w);
    check("rd_bank",  32'(bus.oRD_BANK),  e.rd_bank);
    check("wr_bank",  32'(bus.oWR_BANK),  e.wr_bank);
    check("res_bank", 32'(bus.oRES_BANK), e.res_bank);
    check("wr_en",    32'(bus.oWR_EN),    w.rd_en);
    check("wr_adr0",  32'(bus.oWR_ADR0),  w.a0);
    check("wr_adr1",  32'(bus.oWR_ADR1),  w.a1);
    if (bus.oWR_EN === 1'b1) wr_cnt++;
  endtask

  // One full transform. With hold=1 iSTART stays high the whole time, otherwise it
  // toggles randomly while busy (must be ignored) and drops after DONE.
  task automatic run_check(input bit hold);
    wr_cnt = 0;
    bus.iSTART = 1'b1;
    tick();
    for (int c = 1; c <= TOTAL + 1; c++) begin
      check_cycle(c);
      bus.iSTART = hold ? 1'b1 : ((c <= TOTAL) ? 1'($urandom_range(0, 1)) : 1'b0);
      tick();
    end
    cur_c = TOTAL + 2;
    check("wr_count", 32'(wr_cnt), A_BIT * NH);
    check_zero("idle_after_done");
  endtask

  task automatic idle_gap(input int n);
    bus.iSTART = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      check_zero("idle_gap");
    end
  endtask

  // Start a transform and hit reset asynchronously in the middle of cycle rc.
  task automatic reset_abort(input int rc);
    bus.iSTART = 1'b1;
    tick();
    for (int c = 1; c <= rc; c++) begin
      check_cycle(c);
      if (c < rc) begin
        bus.iSTART = 1'($urandom_range(0, 1));
        tick();
      end
    end
    #2;
    iRESET = 1'b1;
    #1;
    check_zero("async_reset");
    bus.iSTART = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_zero("reset_hold");
    end
    iRESET = 1'b0;
    for (int i = 0; i < TOTAL + 4; i++) begin
      tick();
      check("no_done_after_abort", 32'(bus.oDONE), 0);
    end
    check_zero("idle_after_abort");
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    iRESET = 1'b1;
    bus.iSTART = 1'b0;
    tick();
    tick();
    check_zero("reset_state");
    iRESET = 1'b0;
    tick();
    check_zero("post_reset_idle");

    idle_gap($urandom_range(1, 5));
    run_check(1'b0);

    idle_gap($urandom_range(0, 4));
    run_check(1'b1);
    run_check(1'b1);
    run_check(1'b0);

    idle_gap($urandom_range(1, 3));
    reset_abort(20);
    run_check(1'b0);

    idle_gap($urandom_range(0, 3));
    reset_abort($urandom_range(2, TOTAL));
    run_check(1'b0);

    idle_gap(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
